// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b - bin.
// One full-subtractor cell processes one bit per clock, LSB first.
// Operands enter through a valid/ready handshake, and results leave through another.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow output, ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_br;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             w_d;
  logic             w_br_nxt;
  logic             w_last;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_ovf;
`endif

  // Full-subtractor cell on the current LSBs
  always_comb begin
    w_d      = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
    w_br_nxt = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);
    w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, serial datapath, and result registers
  // Result bits shift into the vacated MSBs of the minuend register.
  // After WIDTH shifts, that register holds the complete difference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_br   <= bin;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_a_sh <= {w_d, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_br   <= w_br_nxt;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff <= {w_d, r_a_sh[WIDTH-1:1]};
            r_bout <= w_br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf  <= r_br ^ w_br_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a scoreboard of expected results.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
`ifdef SERIAL_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mbin);
    exp_t           e;
    logic [WIDTH:0] w;
    int             s;
    w    = {1'b0, ma} - {1'b0, mb} - (WIDTH+1)'(mbin);
    s    = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    e.d  = w[WIDTH-1:0];
    e.bo = w[WIDTH];
    e.ov = (s < -(2 ** (WIDTH - 1))) || (s > (2 ** (WIDTH - 1)) - 1);
    return e;
  endfunction

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb[0];
      check({tag, "_diff"}, 32'(diff), 32'(e.d));
      check({tag, "_bout"}, 32'(bout), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(e.ov));
`endif
    end
  endtask

  // Accept one operand set, wait for the result, optionally stall, then consume it.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tbin, input int hold);
    int n;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a        = ta;
    b        = tb_v;
    bin      = tbin;
    in_valid = 1'b1;
    sb.push_back(model(ta, tb_v, tbin));
    @(posedge clk); #1;
    // Keep in_valid high and scramble operands; RUN must ignore both.
    a   = ~ta;
    b   = ~tb_v;
    bin = ~tbin;
    check("in_ready_run", 32'(in_ready), 32'd0);
    check("busy_run", 32'(busy), 32'd1);
    n = 0;
    while (out_valid !== 1'b1 && n < 4 * WIDTH) begin
      @(posedge clk); #1;
      n++;
      if (n == WIDTH / 2) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
      end
    end
    in_valid = 1'b0;
    check("latency", 32'(n), 32'(WIDTH));
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check_result("hold");
    end
    out_ready = 1'b1;
    check_result("result");
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_clear", 32'(out_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check_result("held_after");
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  initial begin
    int n_ov;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    rst       = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(8'd0,   8'd0,   1'b0, 0);
    run_op(8'd0,   8'd1,   1'b0, 0);
    run_op(8'd255, 8'd255, 1'b1, 0);
    run_op(8'd161, 8'd32,  1'b1, 0);
    run_op(8'd0,   8'd255, 1'b1, 0);
    run_op(8'd200, 8'd100, 1'b0, 5);
    run_op(8'd77,  8'd200, 1'b1, 0);

    // Abort an operation mid-RUN with an asynchronous reset.
    @(negedge clk);
    a = 8'd10; b = 8'd3; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_ov = 0;
    repeat (WIDTH + 4) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) n_ov++;
    end
    check("no_valid_after_rst", 32'(n_ov), 32'd0);
    run_op(8'd10, 8'd3, 1'b0, 0);

    run_op(8'd128, 8'd1, 1'b0, 0);
    run_op(8'd5,   8'd3, 1'b0, 0);
    run_op(8'd127, 8'd255, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor with borrow. It computes diff = a - b - bin and bout, processing one bit per clock from LSB to MSB with a single full-subtractor cell. It is the sequential, inverse-direction companion to the team's ripple eight-bit adder, and shares its operand width and carry/borrow conventions. Operands arrive through a valid/ready input handshake, and results leave through a valid/ready output handshake.

Parameters:
WIDTH, 8, operand and result width in bits; legal values are 2 to 32.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands a, b, bin are valid
in_ready  output  1  block can accept operands; high only in IDLE
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  diff and bout hold a completed result
out_ready  input  1  consumer accepts the result
diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
bout  output  1  borrow-out; 1 when a < b + bin (unsigned)
busy  output  1  high in RUN and DONE

Behaviour:
- Reset: asynchronous and active-high. It forces the following immediately, regardless of clk:
  - state = IDLE
  - in_ready = 1, out_valid = 0, busy = 0
  - diff = 0, bout = 0
  - bit counter = 0, internal borrow = 0, shift registers = 0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: load a and b into shift registers, load bin into the borrow register, clear the counter, go to RUN.
  - Inputs are sampled only on this accept edge; later changes to a, b, bin are ignored.
- RUN:
  - Each edge computes d = a_sh[0] ^ b_sh[0] ^ br.
  - The new borrow is br' = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br).
  - d is shifted into the MSB of the result register (right shift), a_sh and b_sh shift right, and the counter increments.
  - On the edge that processes bit WIDTH-1, go to DONE, set out_valid = 1 and bout = br'.
  - diff shows the full result from that edge onward.
- Latency: out_valid rises exactly WIDTH clocks after the accept edge. in_valid is ignored throughout RUN.
- DONE:
  - out_valid = 1. diff and bout are held stable until the handshake completes.
  - On an edge with out_ready = 1: clear out_valid, go to IDLE.
  - If out_ready stays 0, the block waits indefinitely (back-pressure).
- No overlap: in_ready is 0 in DONE, so a new operand is never accepted on the same edge a result is consumed. Minimum spacing between accepts is WIDTH+2 clocks.
- After the output handshake, diff and bout keep their last values until the next DONE entry. Only out_valid qualifies them.
- Reset asserted mid-RUN or mid-DONE aborts the operation. No out_valid pulse follows reset release.
- Arithmetic wrap-around: 0 - 1 gives diff = 2^WIDTH - 1 with bout = 1. Values a == b with bin = 1 behave the same way.

Optional Feature:
Macro: SERIAL_SUB_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit): signed two's-complement overflow, equal to (borrow into bit WIDTH-1) XOR (borrow out of bit WIDTH-1).
  - ovf is registered on the same edge as bout and held with it.
  - ovf resets to 0.
- When undefined: the port and its logic are absent, and all other behaviour is unchanged.

Test Plan:
1. Reset, then a=0, b=0, bin=0 -> out_valid 8 clocks after accept; diff=0, bout=0; in_ready low during RUN/DONE.
2. a=0, b=1, bin=0 -> diff=255, bout=1. a=255, b=255, bin=1 -> diff=255, bout=1.
3. a=161, b=32, bin=1 -> diff=128, bout=0. a=0, b=255, bin=1 -> diff=0, bout=1.
4. a=200, b=100, bin=0 with out_ready held low 5 clocks -> out_valid and diff=100 stable all 5 clocks; the accept on the first cycle in_ready returns is processed correctly. a, b changed during RUN -> result unaffected.
5. Assert rst 3 clocks after accepting a=10, b=3 -> outputs zero immediately; no out_valid after release; next op a=10, b=3, bin=0 -> diff=7, bout=0.
6. With SERIAL_SUB_OVF_EN: a=128, b=1, bin=0 -> diff=127, bout=0, ovf=1; a=5, b=3 -> ovf=0.
